// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-word width and the team 4-bit op code encoding.
package alu_pkg;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1001;
endpackage

// File: rtl/alu.sv
// Purely combinational ALU; undefined op codes produce 0 (and thus zero=1).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]      a_i,
  input  logic [WIDTH-1:0]      b_i,
  input  logic [ALU_CTRL_W-1:0] ctrl_i,
  output logic [WIDTH-1:0]      result_o,
  output logic                  zero_o
);
  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;

  assign shamt = b_i[SH_W-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SRL:  result_o = a_i >> shamt;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU with a single-entry
// registered output stage. Handshake: a transfer happens on a port when valid
// and ready are both high in the same cycle; senders hold valid/data until then.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [WIDTH-1:0]      req0_a,
  input  logic [WIDTH-1:0]      req0_b,
  input  logic [ALU_CTRL_W-1:0] req0_ctrl,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [WIDTH-1:0]      req1_a,
  input  logic [WIDTH-1:0]      req1_b,
  input  logic [ALU_CTRL_W-1:0] req1_ctrl,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_out,
  output logic                  resp_zero,
  output logic                  resp_id
);
  logic                  resp_valid_q;
  logic [WIDTH-1:0]      resp_out_q;
  logic                  resp_zero_q;
  logic                  resp_id_q;
  logic                  last_grant_q;

  logic                  accept_ok;
  logic                  grant1;
  logic                  grant0;
  logic                  xfer;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_zero;

  assign accept_ok = !resp_valid_q || resp_ready;

  // On a tie, the requester that did not win the previous transfer goes next.
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);
  assign grant0 = req0_valid && !grant1;

  assign req0_ready = grant0 && accept_ok && !reset;
  assign req1_ready = grant1 && accept_ok && !reset;
  assign xfer       = req0_ready || req1_ready;

  assign alu_a    = grant1 ? req1_a    : req0_a;
  assign alu_b    = grant1 ? req1_b    : req0_b;
  assign alu_ctrl = grant1 ? req1_ctrl : req0_ctrl;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .ctrl_i   (alu_ctrl),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_out_q   <= '0;
      resp_zero_q  <= 1'b0;
      resp_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (xfer) begin
      resp_valid_q <= 1'b1;
      resp_out_q   <= alu_result;
      resp_zero_q  <= alu_zero;
      resp_id_q    <= grant1;
      last_grant_q <= grant1;
    end else if (resp_ready) begin
      // Drain without refill: data fields keep their last values.
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_out   = resp_out_q;
  assign resp_zero  = resp_zero_q;
  assign resp_id    = resp_id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a behavioural model.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic         resp_valid, resp_ready;
  logic [W-1:0] resp_out;
  logic         resp_zero, resp_id;

  int tests = 0;
  int fails = 0;

  // Model of the output register and arbitration history.
  logic         m_valid, m_zero, m_id, m_last;
  logic [W-1:0] m_out;
  int           last_g;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_out(resp_out), .resp_zero(resp_zero), .resp_id(resp_id)
  );

  function automatic logic [W-1:0] ref_alu(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    int unsigned sh;
    logic signed [W-1:0] sa;
    sh = b % W;
    sa = a;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a << sh;
      4'd5: return (sa < $signed(b)) ? 1 : 0;
      4'd6: return (a < b) ? 1 : 0;
      4'd7: return a ^ b;
      4'd8: return sa >>> sh;
      4'd9: return a >> sh;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    logic g1, e0, e1, acc;
    logic [W-1:0] r;
    #1;
    acc = !m_valid || resp_ready;
    g1  = req1_valid && (!req0_valid || !m_last);
    e1  = !reset && acc && g1;
    e0  = !reset && acc && req0_valid && !g1;
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_out = 0; m_zero = 0; m_id = 0; m_last = 1;
      exp_q.delete();
    end else if (e0 || e1) begin
      r = e1 ? ref_alu(req1_ctrl, req1_a, req1_b) : ref_alu(req0_ctrl, req0_a, req0_b);
      m_valid = 1; m_out = r; m_zero = (r == 0); m_id = e1; m_last = e1;
      exp_q.push_back(r);
    end else if (resp_ready) begin
      m_valid = 0;
    end
    last_g = e1 ? 1 : (e0 ? 0 : 2);
    @(negedge clk);
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_valid});
    chk("resp_out",   resp_out, m_out);
    chk("resp_zero",  {31'b0, resp_zero}, {31'b0, m_zero});
    chk("resp_id",    {31'b0, resp_id}, {31'b0, m_id});
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_ctrl = 0;
    req1_a = 0; req1_b = 0; req1_ctrl = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; resp_ready = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic set0(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    req0_valid = 1; req0_ctrl = c; req0_a = a; req0_b = b;
  endtask

  task automatic set1(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    req1_valid = 1; req1_ctrl = c; req1_a = a; req1_b = b;
  endtask

  initial begin
    m_valid = 0; m_out = 0; m_zero = 0; m_id = 0; m_last = 1; last_g = 2;
    idle_inputs();
    reset = 1; resp_ready = 1;
    @(negedge clk);

    // Reset state.
    do_reset();
    chk("rst_valid", {31'b0, resp_valid}, 0);
    chk("rst_out", resp_out, 0);

    // Single ADD from req0.
    set0(4'd0, 5, 7);
    step();
    chk("add_grant", last_g, 0);
    chk("add_out", resp_out, 12);
    chk("add_zero", {31'b0, resp_zero}, 0);
    chk("add_id", {31'b0, resp_id}, 0);

    // Dual-valid alternation.
    do_reset();
    set0(4'd1, 9, 9);
    set1(4'd3, 32'hF0, 32'h0F);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_grant", last_g, i % 2);
      chk("alt_out", resp_out, (i % 2) ? 32'hFF : 32'h0);
      chk("alt_zero", {31'b0, resp_zero}, (i % 2) ? 0 : 1);
    end

    // Backpressure with 12 held, then drain-and-refill with no bubble.
    do_reset();
    set0(4'd0, 5, 7);
    step();
    req0_valid = 0;
    set1(4'd7, 3, 5);
    resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out", resp_out, 12);
      chk("bp_ready1", {31'b0, req1_ready}, 0);
    end
    resp_ready = 1;
    step();
    chk("bp_grant", last_g, 1);
    chk("bp_out2", resp_out, 6);
    chk("bp_valid2", {31'b0, resp_valid}, 1);
    req1_valid = 0;
    step();
    chk("drain_valid", {31'b0, resp_valid}, 0);
    chk("drain_hold", resp_out, 6);

    // Boundary op codes through req1.
    set1(4'd8, 32'h8000_0000, 4);
    step();
    chk("sra_out", resp_out, 32'hF800_0000);
    chk("sra_id", {31'b0, resp_id}, 1);
    set1(4'd6, 1, 32'hFFFF_FFFF);
    step();
    chk("sltu_out", resp_out, 1);
    set1(4'd15, 32'h1234, 32'h5678);
    step();
    chk("undef_out", resp_out, 0);
    chk("undef_zero", {31'b0, resp_zero}, 1);
    req1_valid = 0;

    // Reset while a result is held and both requesters wait.
    set0(4'd0, 1, 1);
    step();
    resp_ready = 0;
    set1(4'd0, 2, 2);
    step();
    reset = 1;
    step();
    chk("rst_mid_valid", {31'b0, resp_valid}, 0);
    reset = 0; resp_ready = 1;
    step();
    chk("rst_mid_grant", last_g, 0);

    // Randomized traffic; requesters hold until accepted.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0)
        set0(4'($urandom_range(0, 11)), $urandom, $urandom_range(0, 40));
      if (!req1_valid && $urandom_range(0, 2) != 0)
        set1(4'($urandom_range(0, 11)), $urandom, $urandom_range(0, 40));
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_g == 0) req0_valid = 0;
      if (last_g == 1) req1_valid = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
